// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit:
//   - Size field encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD)
//   - FSM state enum lsu_state_t
//   - lane masks and lane shift helpers for little-endian byte/halfword access
//   Optional feature macro used by the unit: LSU_MISALIGN_TRAP_EN
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR       = 3'd3,
        ST_RESP     = 3'd4
    } lsu_state_t;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    // Bit offset of byte lane k = Addr[1:0] inside a word.
    function automatic logic [4:0] byte_shift(input logic [1:0] off);
        return {off, 3'b000};
    endfunction

    // Bit offset of halfword lane h = Addr[1]; Addr[0] is ignored, which is
    // what gives force-alignment when misalignment trapping is off.
    function automatic logic [4:0] half_shift(input logic [1:0] off);
        return {off[1], 4'b0000};
    endfunction

endpackage

// File: rtl/lsu_lane_format.sv
// -----------------------------------------------------------------------------
// lsu_lane_format
//   Combinational lane handling for the load/store unit.
//   Ports:
//     size        in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//     signed_load in  1   sign-extend sub-word load results
//     byte_off    in  2   Addr[1:0] of the access
//     read_word   in  32  word returned by the data memory
//     store_data  in  32  right-aligned store data
//     load_value  out 32  extracted and extended load result
//     merged_word out 32  read_word with the target lane replaced by store_data
//   Word accesses ignore byte_off entirely.
// -----------------------------------------------------------------------------
module lsu_lane_format
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        signed_load,
    input  logic [1:0]  byte_off,
    input  logic [31:0] read_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [4:0]  b_shift;
    logic [4:0]  h_shift;
    logic [31:0] byte_lane;
    logic [31:0] half_lane;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    assign b_shift   = byte_shift(byte_off);
    assign h_shift   = half_shift(byte_off);
    assign byte_lane = (read_word >> b_shift) & BYTE_MASK;
    assign half_lane = (read_word >> h_shift) & HALF_MASK;

    always_comb begin
        load_value = read_word;
        case (size)
            SZ_BYTE: load_value = (signed_load && byte_lane[7])  ? (byte_lane | ~BYTE_MASK) : byte_lane;
            SZ_HALF: load_value = (signed_load && half_lane[15]) ? (half_lane | ~HALF_MASK) : half_lane;
            default: load_value = read_word;
        endcase
    end

    // Store merge: clear the target lane, then OR in the low bits of the
    // store data shifted into that lane.
    always_comb begin
        lane_mask = 32'hFFFF_FFFF;
        lane_data = store_data;
        case (size)
            SZ_BYTE: begin
                lane_mask = BYTE_MASK << b_shift;
                lane_data = (store_data & BYTE_MASK) << b_shift;
            end
            SZ_HALF: begin
                lane_mask = HALF_MASK << h_shift;
                lane_data = (store_data & HALF_MASK) << h_shift;
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                lane_data = store_data;
            end
        endcase
        merged_word = (read_word & ~lane_mask) | lane_data;
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Single-outstanding load/store initiator between the execute stage and a
//   word-addressed, synchronous-read data memory (Data_Mem). Sub-word stores
//   are read-modify-write because the memory has no byte enables.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   : misaligned halfword/word accesses fault (no memory access)
//     undefined : such accesses are force-aligned; only Size=11 faults
//
//   Ports:
//     Clock, Reset            rising-edge clock, async active-high reset
//     ReqValid/ReqReady       request handshake (accept on both high at edge)
//     IsStore, Size, SignedLoad, Addr, StoreData   request fields
//     RespValid               one-cycle completion pulse
//     LoadData, Misaligned    response fields, valid with RespValid
//     MemAddress, MemWriteData, MemWriteEnable, MemRead   to Data_Mem
//     MemReadData             from Data_Mem, valid the cycle after MemRead
//     DebugState              current FSM state (lsu_state_t encoding)
//
//   Handshake: a request transfers on a rising edge where ReqValid and
//   ReqReady are both high; ReqReady is high only in IDLE, request fields are
//   captured on that edge and inputs are ignored until the unit is idle again.
//   RespValid is high for exactly one cycle per accepted request.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        IsStore,
    input  logic [1:0]  Size,
    input  logic        SignedLoad,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        RespValid,
    output logic [31:0] LoadData,
    output logic        Misaligned,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWriteEnable,
    output logic        MemRead,
    input  logic [31:0] MemReadData,
    output logic [2:0]  DebugState
);

    // Data_Mem is word addressed through a 30-bit word index.
    if (DEPTH_WORDS < 1 || DEPTH_WORDS > (1 << 30)) begin : g_bad_depth
        $error("load_store_unit: DEPTH_WORDS out of range");
    end

    lsu_state_t  state;
    lsu_state_t  next_state;

    logic        accept;
    logic        fault_now;

    logic        is_store_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data_q;
    logic        misaligned_q;

    logic [31:0] load_value;
    logic [31:0] merged_word;

    assign accept = ReqValid && (state == ST_IDLE);

    // Fault decode on the live request so the accept edge can jump straight
    // to RESP without touching memory.
    always_comb begin
        fault_now = (Size == SZ_RSVD);
`ifdef LSU_MISALIGN_TRAP_EN
        if (Size == SZ_HALF && Addr[0])
            fault_now = 1'b1;
        if (Size == SZ_WORD && Addr[1:0] != 2'b00)
            fault_now = 1'b1;
`endif
    end

    // ---------------- state register ----------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (ReqValid) begin
                    if (fault_now)
                        next_state = ST_RESP;
                    else if (IsStore && Size == SZ_WORD)
                        next_state = ST_WR;
                    else
                        next_state = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: next_state = ST_RD_WAIT;
            ST_RD_WAIT:  next_state = is_store_q ? ST_WR : ST_RESP;
            ST_WR:       next_state = ST_RESP;
            ST_RESP:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    // Write enable comes only from the state register, so an asynchronous
    // reset removes it immediately.
    always_comb begin
        ReqReady       = 1'b0;
        RespValid      = 1'b0;
        MemRead        = 1'b0;
        MemWriteEnable = 1'b0;
        case (state)
            ST_IDLE:     ReqReady       = 1'b1;
            ST_RD_ISSUE: MemRead        = 1'b1;
            ST_WR:       MemWriteEnable = 1'b1;
            ST_RESP:     RespValid      = 1'b1;
            default:     ReqReady       = 1'b0;
        endcase
    end

    assign MemAddress   = {2'b00, addr_q[31:2]};
    assign MemWriteData = wdata_q;
    assign LoadData     = load_data_q;
    assign Misaligned   = misaligned_q;
    assign DebugState   = state;

    // ---------------- request / datapath registers ----------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            is_store_q   <= 1'b0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            load_data_q  <= 32'h0;
            misaligned_q <= 1'b0;
        end else if (accept) begin
            is_store_q   <= IsStore;
            size_q       <= Size;
            signed_q     <= SignedLoad;
            addr_q       <= Addr;
            wdata_q      <= StoreData;
            load_data_q  <= 32'h0;
            misaligned_q <= fault_now;
        end else if (state == ST_RD_WAIT) begin
            // MemReadData is valid now, one cycle after MemRead.
            if (is_store_q)
                wdata_q <= merged_word;
            else
                load_data_q <= load_value;
        end
    end

    lsu_lane_format u_lane_format (
        .size        (size_q),
        .signed_load (signed_q),
        .byte_off    (addr_q[1:0]),
        .read_word   (MemReadData),
        .store_data  (wdata_q),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] R = 2'b11;

    logic        Clock;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        IsStore;
    logic [1:0]  Size;
    logic        SignedLoad;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic        RespValid;
    logic [31:0] LoadData;
    logic        Misaligned;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWriteEnable;
    logic        MemRead;
    logic [31:0] MemReadData;
    logic [2:0]  DebugState;

    int total = 0;
    int bad   = 0;

    // ---------------- clock ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- DUT ----------------
    load_store_unit #(.DEPTH_WORDS(1024)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .ReqValid       (ReqValid),
        .ReqReady       (ReqReady),
        .IsStore        (IsStore),
        .Size           (Size),
        .SignedLoad     (SignedLoad),
        .Addr           (Addr),
        .StoreData      (StoreData),
        .RespValid      (RespValid),
        .LoadData       (LoadData),
        .Misaligned     (Misaligned),
        .MemAddress     (MemAddress),
        .MemWriteData   (MemWriteData),
        .MemWriteEnable (MemWriteEnable),
        .MemRead        (MemRead),
        .MemReadData    (MemReadData),
        .DebugState     (DebugState)
    );

    // ---------------- Data_Mem model (sync read, sync write) ----------------
    logic [31:0] mem [0:1023];
    always @(posedge Clock) begin
        if (MemRead)
            MemReadData <= mem[MemAddress[9:0]];
        if (MemWriteEnable)
            mem[MemAddress[9:0]] <= MemWriteData;
    end

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    int          r_lat;
    logic [31:0] r_data;
    logic        r_mis;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_wr_addr;
    logic        r_busy_ready;

    task automatic run_req(input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] d);
        r_lat = -1; r_data = '0; r_mis = 1'b0; r_rd = 1'b0; r_wr = 1'b0;
        r_wr_addr = '0; r_busy_ready = 1'b0;
        @(negedge Clock);
        ReqValid = 1'b1; IsStore = st; Size = sz; SignedLoad = sg; Addr = a; StoreData = d;
        #1 check_val("ready_idle", {31'b0, ReqReady}, 32'd1);
        @(posedge Clock);
        #1 ReqValid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clock);
            if (MemRead) r_rd = 1'b1;
            if (MemWriteEnable) begin
                r_wr = 1'b1;
                r_wr_addr = MemAddress;
            end
            if (RespValid) begin
                r_lat = c; r_data = LoadData; r_mis = Misaligned;
                break;
            end
            if (ReqReady) r_busy_ready = 1'b1;
        end
        if (r_lat < 0) check_val("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_resp(input string tag, input int lat, input logic [31:0] data, input logic mis);
        check_val({tag, "_lat"}, r_lat, lat);
        check_val({tag, "_data"}, r_data, data);
        check_val({tag, "_mis"}, {31'b0, r_mis}, {31'b0, mis});
        check_val({tag, "_busy_ready"}, {31'b0, r_busy_ready}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic resp_seen;

    initial begin
        Reset = 1'b1; ReqValid = 1'b0; IsStore = 1'b0; Size = W; SignedLoad = 1'b0;
        Addr = '0; StoreData = '0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check_val("rst_ready", {31'b0, ReqReady}, 32'd1);
        check_val("rst_resp", {31'b0, RespValid}, 32'd0);
        check_val("rst_ldata", LoadData, 32'd0);
        check_val("rst_mis", {31'b0, Misaligned}, 32'd0);
        check_val("rst_maddr", MemAddress, 32'd0);
        check_val("rst_mwdata", MemWriteData, 32'd0);
        check_val("rst_mwe", {31'b0, MemWriteEnable}, 32'd0);
        check_val("rst_mrd", {31'b0, MemRead}, 32'd0);
        check_val("rst_state", {29'b0, DebugState}, 32'd0);

        // word store then word load
        run_req(1'b1, W, 1'b0, 32'h10, 32'hDEADBEEF);
        check_resp("wst", 2, 32'h0, 1'b0);
        check_val("wst_waddr", r_wr_addr, 32'd4);
        check_val("wst_noread", {31'b0, r_rd}, 32'd0);
        check_val("wst_mem", mem[4], 32'hDEADBEEF);
        run_req(1'b0, W, 1'b0, 32'h10, 32'h0);
        check_resp("wld", 3, 32'hDEADBEEF, 1'b0);
        check_val("wld_read", {31'b0, r_rd}, 32'd1);
        check_val("wld_nowrite", {31'b0, r_wr}, 32'd0);

        // sub-word loads on 0x80FF7F01
        run_req(1'b1, W, 1'b0, 32'h10, 32'h80FF7F01);
        check_resp("wst2", 2, 32'h0, 1'b0);
        run_req(1'b0, B, 1'b1, 32'h10, 32'h0); check_resp("lb10", 3, 32'h00000001, 1'b0);
        run_req(1'b0, B, 1'b1, 32'h11, 32'h0); check_resp("lb11", 3, 32'h0000007F, 1'b0);
        run_req(1'b0, B, 1'b1, 32'h12, 32'h0); check_resp("lb12", 3, 32'hFFFFFFFF, 1'b0);
        run_req(1'b0, B, 1'b1, 32'h13, 32'h0); check_resp("lb13", 3, 32'hFFFFFF80, 1'b0);
        run_req(1'b0, B, 1'b0, 32'h13, 32'h0); check_resp("lbu13", 3, 32'h00000080, 1'b0);
        run_req(1'b0, H, 1'b1, 32'h12, 32'h0); check_resp("lh12", 3, 32'hFFFF80FF, 1'b0);
        run_req(1'b0, H, 1'b0, 32'h10, 32'h0); check_resp("lhu10", 3, 32'h00007F01, 1'b0);
        run_req(1'b0, W, 1'b1, 32'h10, 32'h0); check_resp("lw_sgn", 3, 32'h80FF7F01, 1'b0);

        // sub-word stores (read-modify-write)
        run_req(1'b1, W, 1'b0, 32'h10, 32'h11223344);
        run_req(1'b1, B, 1'b0, 32'h11, 32'h123456AB);
        check_resp("sb11", 4, 32'h0, 1'b0);
        check_val("sb11_mem", mem[4], 32'h1122AB44);
        check_val("sb11_waddr", r_wr_addr, 32'd4);
        run_req(1'b1, H, 1'b0, 32'h12, 32'hFFFFCAFE);
        check_resp("sh12", 4, 32'h0, 1'b0);
        check_val("sh12_mem", mem[4], 32'hCAFEAB44);

        // reserved size always faults
        run_req(1'b0, R, 1'b0, 32'h10, 32'h0);
        check_resp("rsvd", 1, 32'h0, 1'b1);
        check_val("rsvd_noread", {31'b0, r_rd}, 32'd0);
        run_req(1'b1, R, 1'b0, 32'h10, 32'h55555555);
        check_resp("rsvd_st", 1, 32'h0, 1'b1);
        check_val("rsvd_st_nowrite", {31'b0, r_wr}, 32'd0);
        check_val("rsvd_st_mem", mem[4], 32'hCAFEAB44);

        // misaligned accesses
        run_req(1'b0, W, 1'b0, 32'h12, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check_resp("lw12", 1, 32'h0, 1'b1);
        check_val("lw12_noread", {31'b0, r_rd}, 32'd0);
        check_val("lw12_nowrite", {31'b0, r_wr}, 32'd0);
`else
        check_resp("lw12", 3, 32'hCAFEAB44, 1'b0);
`endif
        run_req(1'b0, H, 1'b1, 32'h11, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check_resp("lh11", 1, 32'h0, 1'b1);
`else
        check_resp("lh11", 3, 32'hFFFFAB44, 1'b0);
`endif

        // reset during WR of a word store
        run_req(1'b1, W, 1'b0, 32'h20, 32'h12345678);
        check_val("pre_abort_mem", mem[8], 32'h12345678);
        @(negedge Clock);
        ReqValid = 1'b1; IsStore = 1'b1; Size = W; Addr = 32'h20; StoreData = 32'hFFFFFFFF;
        @(posedge Clock);
        #1 ReqValid = 1'b0;
        @(negedge Clock);
        check_val("abort_mwe_on", {31'b0, MemWriteEnable}, 32'd1);
        #1 Reset = 1'b1;
        #1;
        check_val("abort_mwe_off", {31'b0, MemWriteEnable}, 32'd0);
        check_val("abort_ready", {31'b0, ReqReady}, 32'd1);
        check_val("abort_state", {29'b0, DebugState}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        resp_seen = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            if (RespValid) resp_seen = 1'b1;
        end
        check_val("abort_noresp", {31'b0, resp_seen}, 32'd0);
        check_val("abort_mem", mem[8], 32'h12345678);
        check_val("abort_ready_after", {31'b0, ReqReady}, 32'd1);

        // back-to-back loads with ReqValid held high
        @(negedge Clock);
        ReqValid = 1'b1; IsStore = 1'b0; Size = W; SignedLoad = 1'b0; Addr = 32'h10;
        #1;
        for (int n = 0; n < 8; n++) begin
            check_val($sformatf("b2b_ready_%0d", n), {31'b0, ReqReady}, (n == 0 || n == 4) ? 32'd1 : 32'd0);
            check_val($sformatf("b2b_resp_%0d", n), {31'b0, RespValid}, (n == 3 || n == 7) ? 32'd1 : 32'd0);
            if (n == 3) check_val("b2b_data0", LoadData, 32'hCAFEAB44);
            if (n == 7) check_val("b2b_data1", LoadData, 32'h12345678);
            if (n == 1) Addr = 32'h20;
            if (n == 7) ReqValid = 1'b0;
            @(negedge Clock);
            #1;
        end
        check_val("b2b_idle", {31'b0, ReqReady}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator sitting between the CPU execute stage and `Data_Mem`. It accepts one load or store request at a time, drives the word-addressed, synchronous-read data memory, and returns load data with byte/halfword extraction and sign extension. Sub-word stores use read-modify-write because the memory has no byte enables.

## Interface
- `DEPTH_WORDS`, 1024: data memory depth in 32-bit words.
- `Clock` in 1: rising-edge clock, shared with `Data_Mem`.
- `Reset` in 1: asynchronous, active-high reset.
- `ReqValid` in 1: request present.
- `ReqReady` out 1: unit idle; request accepted on `ReqValid & ReqReady` at a rising edge.
- `IsStore` in 1: 1 = store, 0 = load.
- `Size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `SignedLoad` in 1: sign-extend sub-word loads.
- `Addr` in 32: byte address.
- `StoreData` in 32: store data, right-aligned.
- `RespValid` out 1: one-cycle pulse, request complete.
- `LoadData` out 32: formatted load result, valid with `RespValid`.
- `Misaligned` out 1: fault flag, valid with `RespValid`.
- `MemAddress` out 32: word index `{2'b00, Addr[31:2]}` → `Data_Mem.Address`.
- `MemWriteData` out 32 → `Data_Mem.WriteData`.
- `MemWriteEnable` out 1 → `Data_Mem.WriteEnable`.
- `MemRead` out 1 → `Data_Mem.MemRead`.
- `MemReadData` in 32 ← `Data_Mem.ReadData`; valid the cycle after `MemRead`.

## Operation
- Request fields are latched on accept; inputs are ignored while busy.
- States: IDLE, RD_ISSUE, RD_WAIT, WR, RESP.
- IDLE: `ReqReady`=1. On accept:
  - fault → RESP;
  - load or sub-word store → RD_ISSUE;
  - word store → WR.
- RD_ISSUE: `MemRead`=1, `MemAddress` is the word index → RD_WAIT.
- RD_WAIT: sample `MemReadData`.
  - Load: register `LoadData`, then → RESP.
  - Sub-word store: merge into the write-data register, then → WR.
- WR: `MemWriteEnable`=1, `MemWriteData` stable → RESP.
- RESP: `RespValid`=1 for exactly one cycle → IDLE. A new request is accepted no earlier than the following IDLE cycle.
- Lanes are little-endian.
  - Byte k = `Addr[1:0]` occupies bits [8k+7:8k].
  - Halfword h = `Addr[1]` occupies bits [16h+15:16h].
- Loads:
  - Extracted lane is zero-extended, or sign-extended when `SignedLoad`=1.
  - Word loads ignore `SignedLoad`.
- Sub-word stores replace only the target lane with the low 8/16 bits of `StoreData`; all other bits are preserved.
- Fault (see Configuration): no memory read or write is issued, `LoadData`=0, `Misaligned`=1.
- `Size`=11 always faults.
- `MemAddress`, `MemWriteData`, `MemWriteEnable` and `MemRead` are decoded from the state and latched registers. They never glitch to write outside WR.

## Timing
- Reset values: state IDLE, `ReqReady`=1, `RespValid`=0, `LoadData`=0, `Misaligned`=0, `MemAddress`=0, `MemWriteData`=0, `MemWriteEnable`=0, `MemRead`=0.
- Latency, counted from the accept edge to the `RespValid` cycle:
  - load: 3 cycles;
  - word store: 2 cycles;
  - sub-word store: 4 cycles;
  - fault: 1 cycle.
- Write commits at the rising edge that ends WR.
- Reset asserted mid-operation:
  - aborts immediately and returns to IDLE;
  - `MemWriteEnable` drops asynchronously, so a write in progress is not committed unless its edge precedes the reset;
  - no `RespValid` is generated for the aborted request.
- `ReqValid` held high continuously: back-to-back requests are accepted on each IDLE cycle.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - halfword with `Addr[0]`=1 faults;
  - word with `Addr[1:0]`≠0 faults.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - those accesses are force-aligned (halfword uses `Addr[1]`, word ignores `Addr[1:0]`);
  - `Misaligned` stays 0 except for `Size`=11.

## Structure
- Package `lsu_pkg`:
  - `Size` encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - state enum `lsu_state_t`;
  - lane-select helper constants.
- One sub-module, `lsu_lane_format`: combinational load extraction/extension plus store-lane merge; the FSM stays in `load_store_unit`.

## Test plan
- Word store `Addr`=0x10, `StoreData`=0xDEADBEEF, then word load `Addr`=0x10 → `MemAddress`=4 in WR, `LoadData`=0xDEADBEEF 3 cycles after accept, `Misaligned`=0.
- Memory word 4 = 0x80FF7F01; byte loads at 0x10–0x13 signed → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; unsigned byte at 0x13 → 0x00000080.
- Memory word 4 = 0x11223344; byte store 0xAB to 0x11 → word becomes 0x1122AB44, response 4 cycles after accept; halfword store 0xCAFE to 0x12 → 0xCAFEAB44.
- Macro defined: word load `Addr`=0x12 → `RespValid` 1 cycle after accept, `Misaligned`=1, `LoadData`=0, no `MemRead`/`MemWriteEnable`. Macro undefined: the same request returns word 4.
- `Reset` pulsed during WR of a word store → `MemWriteEnable` falls immediately, memory unchanged, `ReqReady`=1, no `RespValid`.
- `ReqValid` held high with two loads → second accepted the cycle after the first `RespValid`, `ReqReady`=0 throughout each transaction.
